// File: rtl/fade_pkg.sv
// Shared fade/pwm definitions: FSM state encoding and default timing constants
// for the 12 MHz system clock.
package fade_pkg;

  typedef enum logic [1:0] {
    RAMP_UP   = 2'd0,
    HOLD_HIGH = 2'd1,
    RAMP_DOWN = 2'd2,
    HOLD_LOW  = 2'd3
  } fade_state_t;

  localparam int unsigned DEF_PWM_INTERVAL     = 1200;
  localparam int unsigned DEF_INC_DEC_MAX      = 200;
  localparam int unsigned DEF_INC_DEC_INTERVAL = 12000;
  localparam int unsigned DEF_HOLD_STEPS       = 200;

endpackage

// File: rtl/fade_ctrl_tick_timer.sv
// Free-running step timer: counts enabled clocks and pulses tick (combinational)
// on the clock where the count wraps from INTERVAL-1 to 0.
module tick_timer #(
  parameter int unsigned INTERVAL = 12000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (en) begin
      if (cnt_q == CW'(INTERVAL - 1)) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fade_ctrl.sv
// LED fade controller: ramps pwm_value 0 -> PWM_INTERVAL, holds, ramps back to 0,
// holds, repeating; each phase advances one step per timer tick.
module fade_ctrl
  import fade_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL     = DEF_PWM_INTERVAL,
  parameter int unsigned INC_DEC_MAX      = DEF_INC_DEC_MAX,
  parameter int unsigned INC_DEC_INTERVAL = DEF_INC_DEC_INTERVAL,
  parameter int unsigned HOLD_STEPS       = DEF_HOLD_STEPS,
  parameter int unsigned INC_DEC_VAL      = PWM_INTERVAL / INC_DEC_MAX
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  output logic [$clog2(PWM_INTERVAL)-1:0] pwm_value,
  output logic [1:0]                      state,
  output logic                            cycle_done
);

  localparam int unsigned PW       = $clog2(PWM_INTERVAL);
  localparam int unsigned STEP_MAX = (INC_DEC_MAX > HOLD_STEPS) ? INC_DEC_MAX : HOLD_STEPS;
  localparam int unsigned SW       = (STEP_MAX > 1) ? $clog2(STEP_MAX) : 1;

  logic tick;

  fade_state_t   state_q, state_d;
  logic [PW-1:0] pwm_value_q, pwm_value_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  logic          cycle_done_q, cycle_done_d;
  logic          last_ramp_step, last_hold_step;

  tick_timer #(
    .INTERVAL (INC_DEC_INTERVAL)
  ) u_tick_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  assign last_ramp_step = (step_cnt_q == SW'(INC_DEC_MAX - 1));
  assign last_hold_step = (step_cnt_q == SW'(HOLD_STEPS - 1));

  // Ramp endpoints are forced so the duty word never overshoots or wraps.
  always_comb begin
    state_d      = state_q;
    pwm_value_d  = pwm_value_q;
    step_cnt_d   = step_cnt_q;
    cycle_done_d = 1'b0;
    if (tick) begin
      case (state_q)
        RAMP_UP: begin
          if (last_ramp_step) begin
            state_d     = HOLD_HIGH;
            step_cnt_d  = '0;
            pwm_value_d = PW'(PWM_INTERVAL);
          end else begin
            pwm_value_d = pwm_value_q + PW'(INC_DEC_VAL);
            step_cnt_d  = step_cnt_q + SW'(1);
          end
        end
        HOLD_HIGH: begin
          if (last_hold_step) begin
            state_d    = RAMP_DOWN;
            step_cnt_d = '0;
          end else begin
            step_cnt_d = step_cnt_q + SW'(1);
          end
        end
        RAMP_DOWN: begin
          if (last_ramp_step) begin
            state_d     = HOLD_LOW;
            step_cnt_d  = '0;
            pwm_value_d = '0;
          end else begin
            pwm_value_d = pwm_value_q - PW'(INC_DEC_VAL);
            step_cnt_d  = step_cnt_q + SW'(1);
          end
        end
        HOLD_LOW: begin
          if (last_hold_step) begin
            state_d      = RAMP_UP;
            step_cnt_d   = '0;
            cycle_done_d = 1'b1;
          end else begin
            step_cnt_d = step_cnt_q + SW'(1);
          end
        end
        default: state_d = RAMP_UP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RAMP_UP;
      pwm_value_q  <= '0;
      step_cnt_q   <= '0;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pwm_value_q  <= pwm_value_d;
      step_cnt_q   <= step_cnt_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign pwm_value  = pwm_value_q;
  assign state      = state_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_fade_ctrl.sv
// Directed bench for fade_ctrl with a scaled-down timing set
// (interval 12, 4 steps of 3, 3 clocks per tick, 2 hold ticks).
module tb_fade_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] pwm_value;
  logic [1:0] state;
  logic       cycle_done;

  int n_vec  = 0;
  int n_fail = 0;

  fade_ctrl #(
    .PWM_INTERVAL     (12),
    .INC_DEC_MAX      (4),
    .INC_DEC_INTERVAL (3),
    .HOLD_STEPS       (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pwm_value  (pwm_value),
    .state      (state),
    .cycle_done (cycle_done)
  );

  always #5 clk = ~clk;

  // One clock edge; outputs are sampled and inputs driven 1 time unit later.
  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    en  = 1'b1;
    clk_step();
    clk_step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    if (pwm_value !== 4'd0) begin n_fail++; $display("FAIL reset_pwm: got %0d expected 0", pwm_value); end
    n_vec++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_vec++;
    if (cycle_done !== 1'b0) begin n_fail++; $display("FAIL reset_cycle_done: got %0d expected 0", cycle_done); end
    n_vec++;
  endtask

  // Profile over three full cycles: key points, pulse count, endpoint clamps.
  task automatic test_profile();
    int ck_tab[19]  = '{2, 3, 6, 9, 11, 12, 17, 18, 21, 27, 29, 30, 35, 36, 37, 39, 71, 72, 73};
    int pwm_tab[19] = '{0, 3, 6, 9,  9, 12, 12, 12,  9,  3,  3,  0,  0,  0,  0,  3,  0,  0,  0};
    int st_tab[19]  = '{0, 0, 0, 0,  0,  1,  1,  2,  2,  2,  2,  3,  3,  0,  0,  0,  3,  0,  0};
    int cd_tab[19]  = '{0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  0,  0,  1,  0,  0,  0,  1,  0};
    int ti = 0;
    int pulses = 0;
    int pv;
    apply_reset();
    for (int ck = 1; ck <= 108; ck++) begin
      clk_step();
      pv = int'(pwm_value);
      n_vec++;
      if (pv > 12 || (pv % 3) != 0) begin
        n_fail++;
        $display("FAIL clamp@%0d: got pwm %0d expected multiple of 3 in 0..12", ck, pv);
      end
      if (ck <= 72 && cycle_done === 1'b1) pulses++;
      if (ti < 19 && ck == ck_tab[ti]) begin
        n_vec++;
        if (pwm_value !== 4'(pwm_tab[ti])) begin
          n_fail++;
          $display("FAIL pwm@%0d: got %0d expected %0d", ck, pwm_value, pwm_tab[ti]);
        end
        n_vec++;
        if (state !== 2'(st_tab[ti])) begin
          n_fail++;
          $display("FAIL state@%0d: got %0d expected %0d", ck, state, st_tab[ti]);
        end
        n_vec++;
        if (cycle_done !== 1'(cd_tab[ti])) begin
          n_fail++;
          $display("FAIL cycle_done@%0d: got %0d expected %0d", ck, cycle_done, cd_tab[ti]);
        end
        ti++;
      end
    end
    check("cycle_done_pulses_72clk", pulses, 2);
    check("profile_points_visited", ti, 19);
  endtask

  // en dropped with a partial timer count: no lost or extra tick.
  task automatic test_en_gating();
    apply_reset();
    for (int i = 1; i <= 4; i++) clk_step();
    check("gate_pwm_before_drop", int'(pwm_value), 3);
    en = 1'b0;
    for (int i = 5; i <= 9; i++) begin
      clk_step();
      check("gate_pwm_frozen", int'(pwm_value), 3);
    end
    en = 1'b1;
    clk_step();
    check("gate_pwm_edge10", int'(pwm_value), 3);
    clk_step();
    check("gate_pwm_edge11", int'(pwm_value), 6);
    clk_step();
    clk_step();
    check("gate_pwm_edge13", int'(pwm_value), 6);
    clk_step();
    check("gate_pwm_edge14", int'(pwm_value), 9);
    check("gate_state_edge14", int'(state), 0);
  endtask

  task automatic test_mid_reset();
    apply_reset();
    for (int i = 1; i <= 10; i++) clk_step();
    check("mreset_pwm_before", int'(pwm_value), 9);
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    check("mreset_pwm_after", int'(pwm_value), 0);
    check("mreset_state_after", int'(state), 0);
    clk_step();
    clk_step();
    check("mreset_pwm_clk2", int'(pwm_value), 0);
    clk_step();
    check("mreset_pwm_clk3", int'(pwm_value), 3);
    for (int i = 4; i <= 12; i++) clk_step();
    check("mreset_pwm_clk12", int'(pwm_value), 12);
    check("mreset_state_clk12", int'(state), 1);
  endtask

  initial begin
    test_reset();
    test_profile();
    test_en_gating();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
